j1_boot_loader: RTL

//  Boot sequencer for the J1B core and its shared 8K x 32 code/data RAM.

---
 rtl/j1_boot_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/j1_boot_loader.sv
// j1_boot_loader: boot sequencer for the J1B core and its shared code/data RAM.
// Holds the CPU in reset, receives a length-prefixed byte image, packs it into
// little-endian 32-bit words and writes them to the RAM, then releases the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing 32-bit XOR checksum
// that must match before the CPU is released.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_HDR0 | waiting for LEN_LO
//   S_HDR1 | waiting for LEN_HI; validates the word count
//   S_DATA | packing payload bytes into words and writing them
//   S_CSUM | collecting the 4-byte checksum (BOOT_CHECKSUM_EN only)
//   S_RUN  | image loaded, CPU released; terminal until reset
//   S_ERR  | image rejected, CPU held in reset; terminal until reset
module j1_boot_loader #(
    parameter int ADDR_W    = 13,
    parameter int MAX_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              cpu_resetq,
    output logic              done,
    output logic              error
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_RUN, S_ERR} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [7:0]        len_lo;
    logic [15:0]       len_m1;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [23:0]       word_buf;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       csum_acc;
`endif

    logic              xfer;
    logic              word_done;
    logic              last_word;
    logic [15:0]       hdr_len;
    logic [31:0]       cur_word;

    assign xfer      = rx_valid & rx_ready;
    assign word_done = xfer && (byte_cnt == 2'd3);
    assign hdr_len   = {rx_data, len_lo};
    assign cur_word  = {rx_data, word_buf};
    // word counter is one bit wider than the address so N == MAX_WORDS never wraps early
    assign last_word = ({{(31-ADDR_W){1'b0}}, word_cnt} == {16'd0, len_m1});

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_HDR0;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_HDR0: if (xfer) next_state = S_HDR1;
            S_HDR1: begin
                if (xfer) begin
                    if ({16'd0, hdr_len} > 32'(MAX_WORDS)) next_state = S_ERR;
`ifdef BOOT_CHECKSUM_EN
                    else if (hdr_len == 16'd0)             next_state = S_CSUM;
`else
                    else if (hdr_len == 16'd0)             next_state = S_RUN;
`endif
                    else                                   next_state = S_DATA;
                end
            end
            S_DATA: begin
`ifdef BOOT_CHECKSUM_EN
                if (word_done && last_word) next_state = S_CSUM;
`else
                if (word_done && last_word) next_state = S_RUN;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: if (word_done) next_state = (cur_word == csum_acc) ? S_RUN : S_ERR;
`endif
            default: next_state = state;
        endcase
    end

    // datapath and registered outputs; status outputs follow the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ready   <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_resetq <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_lo     <= '0;
            len_m1     <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_buf   <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_acc   <= '0;
`endif
        end else begin
            rx_ready   <= (next_state != S_RUN) && (next_state != S_ERR);
            cpu_resetq <= (next_state == S_RUN);
            done       <= (next_state == S_RUN);
            error      <= (next_state == S_ERR);
            ram_wr     <= 1'b0;
            if (xfer) begin
                case (state)
                    S_HDR0: len_lo <= rx_data;
                    S_HDR1: begin
                        len_m1   <= hdr_len - 16'd1;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {rx_data, word_buf[23:8]};
                        if (byte_cnt == 2'd3) begin
                            ram_wr    <= 1'b1;
                            ram_addr  <= word_cnt[ADDR_W-1:0];
                            ram_wdata <= cur_word;
                            word_cnt  <= word_cnt + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            csum_acc  <= csum_acc ^ cur_word;
`endif
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    S_CSUM: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {rx_data, word_buf[23:8]};
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
